// File: rtl/hidden_cpu_drv_pkg.sv
// Shared types and bit positions for the tiny-CPU host driver.
// Holds the driver state enum, the cpuIn bus layout and the instruction field widths.
package hidden_cpu_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RSTL,
        RSTH,
        SETUP,
        HIGH,
        FIN
    } drv_state_t;

    localparam int CLK_BIT   = 0;
    localparam int RST_BIT   = 1;
    localparam int INSTR_LSB = 2;

    localparam int OPCODE_W     = 2;
    localparam int ADDR_FIELD_W = 4;
    localparam int INSTR_W      = OPCODE_W + ADDR_FIELD_W;
    localparam int OPCODE_LSB   = ADDR_FIELD_W;

    function automatic logic [7:0] cpu_word(input logic [INSTR_W-1:0] instr,
                                            input logic               cpu_rst,
                                            input logic               cpu_clk);
        logic [7:0] w;
        w                         = 8'h00;
        w[INSTR_LSB +: INSTR_W]   = instr;
        w[RST_BIT]                = cpu_rst;
        w[CLK_BIT]                = cpu_clk;
        return w;
    endfunction

endpackage

// File: rtl/hidden_cpu_res_fifo.sv
// Synchronous result FIFO for the CPU driver; head is presented combinationally.
// An empty FIFO presents zero on pop_data so the consumer never sees stale data.
module hidden_cpu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/hidden_cpu_driver.sv
// Host-side driver that clocks, resets and feeds instructions to the tiny CPU.
// Result FIFO and back-pressure stall exist only with HIDDEN_CPU_DRIVER_TRACE_EN defined.
//   state | meaning
//   IDLE  | cpuIn=0, program buffer writable, waiting for start
//   RSTL  | CPU reset asserted, CPU clock low
//   RSTH  | CPU reset asserted, CPU clock high (the reset edge)
//   SETUP | instruction presented, CPU clock low; may stall on a full FIFO
//   HIGH  | instruction held, CPU clock high; result captured on last cycle
//   FIN   | one-cycle done pulse
module hidden_cpu_driver
    import hidden_cpu_drv_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int HALF_PERIOD = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     progWe,
    input  logic [$clog2(DEPTH)-1:0] progAddr,
    input  logic [INSTR_W-1:0]       progData,
    input  logic                     start,
    input  logic [7:0]               stepCount,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               cpuIn,
    input  logic [7:0]               cpuOut,
    output logic                     resValid,
    output logic [7:0]               resData,
    input  logic                     resReady
);

    localparam int PAW = $clog2(DEPTH);
    localparam int HPW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HPW-1:0] PHASE_LOAD = HPW'(HALF_PERIOD - 1);

    drv_state_t           state;
    drv_state_t           state_next;
    logic [HPW-1:0]       phase_cnt;
    logic                 phase_last;
    logic [7:0]           steps;
    logic [PAW-1:0]       iptr;
    logic [INSTR_W-1:0]   instr_mem [DEPTH];
    logic [INSTR_W-1:0]   cur_instr;
    logic                 step_done;
    logic                 fifo_full;
    logic [7:0]           cpu_word_c;

    assign phase_last = (phase_cnt == '0);
    assign cur_instr  = instr_mem[iptr];

    // Program buffer is deliberately not reset so it survives across runs.
    always_ff @(posedge clk) begin
        if (progWe && state == IDLE) instr_mem[progAddr] <= progData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            phase_cnt <= '0;
            steps     <= '0;
            iptr      <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                phase_cnt <= PHASE_LOAD;
            else if (phase_cnt != '0)
                phase_cnt <= phase_cnt - 1'b1;

            if (state == IDLE && start) begin
                steps <= stepCount;
                iptr  <= '0;
            end else if (step_done) begin
                steps <= steps - 1'b1;
                iptr  <= iptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cpu_word_c = 8'h00;
        step_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RSTL;
            end
            RSTL: begin
                cpu_word_c = cpu_word(6'd0, 1'b1, 1'b0);
                if (phase_last) state_next = RSTH;
            end
            RSTH: begin
                cpu_word_c = cpu_word(6'd0, 1'b1, 1'b1);
                if (phase_last) state_next = (steps != 8'd0) ? SETUP : FIN;
            end
            SETUP: begin
                cpu_word_c = cpu_word(cur_instr, 1'b0, 1'b0);
                if (phase_last && !fifo_full) state_next = HIGH;
            end
            HIGH: begin
                cpu_word_c = cpu_word(cur_instr, 1'b0, 1'b1);
                if (phase_last) begin
                    step_done  = 1'b1;
                    state_next = (steps == 8'd1) ? FIN : SETUP;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cpuIn = cpu_word_c;
    assign busy  = (state != IDLE);
    assign done  = (state == FIN);

`ifdef HIDDEN_CPU_DRIVER_TRACE_EN
    logic fifo_empty;

    hidden_cpu_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (step_done),
        .push_data (cpuOut),
        .pop       (resValid && resReady),
        .pop_data  (resData),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign resValid = !fifo_empty;
`else
    logic unused_inputs;
    assign unused_inputs = ^{resReady, cpuOut};
    assign fifo_full     = 1'b0;
    assign resValid      = 1'b0;
    assign resData       = 8'h00;
`endif

endmodule

// File: tb/tb_hidden_cpu_driver.sv
// Self-checking bench for hidden_cpu_driver with a behavioural tiny-CPU on the pin bus.
// Result checks depend on whether HIDDEN_CPU_DRIVER_TRACE_EN is defined for the build.
module tb_hidden_cpu_driver;

    localparam int DEPTH = 16;
    localparam int HP    = 2;
    localparam int FD    = 4;
`ifdef HIDDEN_CPU_DRIVER_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif
    localparam logic [31:0] RESET_REGS = 32'h0302_0100;

    typedef struct {
        int n;
        int exp_done;
        bit rand_ready;
        bit poke;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       progWe = 1'b0;
    logic [3:0] progAddr = '0;
    logic [5:0] progData = '0;
    logic       start = 1'b0;
    logic [7:0] stepCount = '0;
    logic       resReady = 1'b0;
    logic       busy, done, resValid;
    logic [7:0] cpuIn, cpuOut, resData;

    int n_cmp  = 0;
    int n_fail = 0;
    int bad_res = 0;
    bit rdy_rand = 1'b0;

    logic [5:0]  prog_m [DEPTH];
    logic [5:0]  instr_q [$];
    logic [7:0]  got_q [$];
    logic [7:0]  trace_q [$];
    logic [31:0] cpu_regs = RESET_REGS;
    wire         cpu_clk = cpuIn[0];

    hidden_cpu_driver #(.DEPTH(DEPTH), .HALF_PERIOD(HP), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .progWe(progWe), .progAddr(progAddr), .progData(progData),
        .start(start), .stepCount(stepCount), .busy(busy), .done(done), .cpuIn(cpuIn),
        .cpuOut(cpuOut), .resValid(resValid), .resData(resData), .resReady(resReady)
    );

    always #5 clk = ~clk;

    // Tiny CPU ISA: r[d] op= r[s]; add, move, invert, rotate-xor. cpuOut shows r3.
    function automatic logic [31:0] cpu_exec(input logic [31:0] r, input logic [5:0] ins);
        logic [7:0] d, s;
        int di, si;
        di = int'(ins[3:2]);
        si = int'(ins[1:0]);
        d  = r[8*di +: 8];
        s  = r[8*si +: 8];
        case (ins[5:4])
            2'd0:    d = d + s;
            2'd1:    d = s;
            2'd2:    d = ~s;
            default: d = {d[6:0], d[7]} ^ s;
        endcase
        r[8*di +: 8] = d;
        return r;
    endfunction

    assign cpuOut = cpu_regs[31:24];

    always @(posedge cpu_clk) begin
        if (cpuIn[1]) cpu_regs = RESET_REGS;
        else begin
            cpu_regs = cpu_exec(cpu_regs, cpuIn[7:2]);
            instr_q.push_back(cpuIn[7:2]);
        end
    end

    always @(negedge clk) begin
        if (rst && resValid && resReady) got_q.push_back(resData);
        if (resValid !== 1'b0 || resData !== 8'h00) bad_res++;
    end

    always @(posedge clk) begin
        #1;
        if (rdy_rand) resReady = 1'($urandom_range(0, 1));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected bus word on cycle c (1 = first cycle after start sampled) of an unstalled run.
    function automatic logic [7:0] exp_word(input int c, input int n);
        int k, ph;
        if (c <= HP)          return 8'h02;
        if (c <= 2*HP)        return 8'h03;
        if (c > 2*HP*(n + 1)) return 8'h00;
        k  = (c - 2*HP - 1) / (2*HP);
        ph = (c - 2*HP - 1) % (2*HP);
        return {prog_m[k % DEPTH], 1'b0, (ph >= HP) ? 1'b1 : 1'b0};
    endfunction

    task automatic load(input int a, input logic [5:0] d);
        @(posedge clk); #1;
        progWe = 1'b1; progAddr = 4'(a); progData = d;
        @(posedge clk); #1;
        progWe = 1'b0;
        prog_m[a] = d;
    endtask

    task automatic check_outputs(input int n);
        logic [31:0] r;
        r = RESET_REGS;
        chk("instr_count", instr_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < instr_q.size()) chk("instr_order", instr_q[k], prog_m[k % DEPTH]);
            r = cpu_exec(r, prog_m[k % DEPTH]);
`ifdef HIDDEN_CPU_DRIVER_TRACE_EN
            if (k < got_q.size()) chk("result_r3", got_q[k], r[31:24]);
`endif
        end
        chk("result_count", got_q.size(), TRACE ? n : 0);
    endtask

    task automatic do_run(input vec_t v);
        int done_at;
        got_q.delete(); instr_q.delete(); trace_q.delete();
        done_at = -1;
        @(posedge clk); #1;
        if (v.rand_ready) rdy_rand = 1'b1;
        else resReady = 1'b1;
        start = 1'b1; stepCount = 8'(v.n);
        @(posedge clk); #1;
        start = 1'b0; stepCount = 8'($urandom);
        for (int c = 1; c <= 4000; c++) begin
            @(negedge clk);
            trace_q.push_back(cpuIn);
            if (c == 1) begin
                chk("start_rst_rise", cpuIn[1], 1);
                chk("busy_in_run", busy, 1);
            end
            if (v.poke && c == 1) begin
                progWe = 1'b1; progAddr = 4'd0; progData = ~prog_m[0]; start = 1'b1;
            end else if (v.poke && c == 2) begin
                progWe = 1'b0; start = 1'b0;
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        chk("done_seen", (done_at > 0) ? 1 : 0, 1);
        if (v.exp_done >= 0) begin
            chk("done_cycle", done_at, v.exp_done);
            for (int c = 1; c <= trace_q.size(); c++)
                chk("cpuIn_trace", trace_q[c-1], exp_word(c, v.n));
        end
        rdy_rand = 1'b0;
        @(posedge clk); #2;
        resReady = 1'b1;
        @(negedge clk);
        chk("idle_after_fin", busy, 0);
        chk("done_one_cycle", done, 0);
        repeat (FD + 2) @(posedge clk);
        check_outputs(v.n);
    endtask

    vec_t vecs [6];
    vec_t rv;
    int   found;

    initial begin
        vecs[0] = '{n: 3,  exp_done: 17, rand_ready: 1'b0, poke: 1'b0};
        vecs[1] = '{n: 0,  exp_done: 5,  rand_ready: 1'b0, poke: 1'b1};
        vecs[2] = '{n: 1,  exp_done: 9,  rand_ready: 1'b0, poke: 1'b0};
        vecs[3] = '{n: 20, exp_done: 85, rand_ready: 1'b0, poke: 1'b0};
        vecs[4] = '{n: 7,  exp_done: 33, rand_ready: 1'b0, poke: 1'b0};
        vecs[5] = '{n: 16, exp_done: 69, rand_ready: 1'b0, poke: 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_cpuIn", cpuIn, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_resValid", resValid, 0);
        chk("reset_resData", resData, 8'h00);

        for (int a = 0; a < DEPTH; a++) load(a, 6'($urandom));
        load(0, 6'h05); load(1, 6'h2A); load(2, 6'h3F);

        // Asynchronous reset while idle.
        @(negedge clk); #2 rst = 1'b0;
        #1;
        chk("idle_rst_cpuIn", cpuIn, 8'h00);
        chk("idle_rst_busy", busy, 0);
        chk("idle_rst_resValid", resValid, 0);
        @(posedge clk); #1 rst = 1'b1;

        for (int i = 0; i < 6; i++) do_run(vecs[i]);

`ifdef HIDDEN_CPU_DRIVER_TRACE_EN
        // Back-pressure: FIFO fills after four steps, then SETUP holds the CPU clock low.
        @(posedge clk); #1;
        resReady = 1'b0; instr_q.delete(); got_q.delete();
        start = 1'b1; stepCount = 8'd6;
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("stall_issued", instr_q.size(), 4);
        chk("stall_cpu_clk", cpuIn[0], 0);
        chk("stall_instr", cpuIn[7:2], prog_m[4]);
        chk("stall_busy", busy, 1);
        chk("stall_resValid", resValid, 1);
        #1 resReady = 1'b1;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin found = 1; break; end
        end
        chk("stall_done_seen", found, 1);
        repeat (FD + 2) @(posedge clk);
        check_outputs(6);
`endif

        // Asynchronous reset during the second HIGH phase, then a clean run.
        @(posedge clk); #1;
        resReady = 1'b0; instr_q.delete();
        start = 1'b1; stepCount = 8'd5;
        @(posedge clk); #1 start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (instr_q.size() >= 2 && cpuIn[0] && !cpuIn[1]) begin found = 1; break; end
        end
        chk("reach_high", found, 1);
`ifdef HIDDEN_CPU_DRIVER_TRACE_EN
        chk("fifo_had_entry", resValid, 1);
`endif
        #2 rst = 1'b0;
        #1;
        chk("midrun_rst_cpuIn", cpuIn, 8'h00);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_resValid", resValid, 0);
        chk("midrun_rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b1;
        rv = '{n: 4, exp_done: 21, rand_ready: 1'b0, poke: 1'b0};
        do_run(rv);

        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 4; j++) load(int'($urandom_range(0, DEPTH-1)), 6'($urandom));
            rv.n          = int'($urandom_range(0, 40));
            rv.rand_ready = 1'($urandom_range(0, 1));
            rv.poke       = 1'b0;
            rv.exp_done   = (!TRACE || !rv.rand_ready) ? 2*HP*(rv.n + 1) + 1 : -1;
            do_run(rv);
        end

`ifndef HIDDEN_CPU_DRIVER_TRACE_EN
        chk("no_fifo_outputs_quiet", bad_res, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hidden_cpu_driver.md
# hidden_cpu_driver

Host-side driver for the 8-bit tiny CPU. It owns the other end of the CPU's pin interface: it generates the CPU's clock, reset and 6-bit instruction field on the CPU's 8-bit input bus, and captures the CPU's 8-bit output bus after every CPU clock edge. Programs are loaded into a small instruction buffer and replayed for a requested number of CPU cycles. Results are handed out through a ready/valid result FIFO.

## Interface
Parameters:
- DEPTH, 16, number of 6-bit instruction slots; power of two.
- HALF_PERIOD, 2, system cycles per CPU clock half-period; ≥1.
- FIFO_DEPTH, 4, number of result FIFO entries; power of two.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- progWe  in  1  instruction buffer write strobe.
- progAddr  in  log2(DEPTH)  instruction slot address.
- progData  in  6  instruction, as {opcode[1:0], addrs[3:0]}.
- start  in  1  begin a run.
- stepCount  in  8  number of CPU cycles to run; sampled with start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run finishes.
- cpuIn  out  8  drives the CPU input bus: [0]=CPU clock, [1]=CPU reset (active-high), [7:2]=instruction.
- cpuOut  in  8  CPU output bus.
- resValid  out  1  FIFO head valid.
- resData  out  8  FIFO head.
- resReady  in  1  consumer accepts the head.

## Operation
- States are IDLE, RSTL, RSTH, SETUP, HIGH, and FIN.
- **IDLE:**
  - cpuIn=0x00.
  - progWe writes the instruction buffer; writes are ignored when busy=1.
  - start=1 latches stepCount into a step counter, clears the instruction pointer iptr, and moves to RSTL. start is ignored when busy=1.
- **RSTL:** cpuIn={6'b0,1,0} for HALF_PERIOD cycles, then RSTH.
- **RSTH:**
  - cpuIn={6'b0,1,1} for HALF_PERIOD cycles. This is one CPU rising edge with reset asserted.
  - Then SETUP if the step counter is nonzero, else FIN.
- **SETUP:**
  - cpuIn={buf[iptr],0,0}.
  - Leave after HALF_PERIOD cycles, and only when the FIFO is not full. Otherwise hold with the CPU clock low (stall).
- **HIGH:**
  - cpuIn={buf[iptr],0,1} for HALF_PERIOD cycles.
  - On the last cycle, push cpuOut into the FIFO, increment iptr modulo DEPTH, and decrement the step counter.
  - Then SETUP if the counter is nonzero, else FIN.
- **FIN:** done=1 for one cycle, cpuIn=0x00, then IDLE.
- busy=1 in every state except IDLE.
- FIFO pop occurs when resValid&&resReady.
- A pop and a push in the same cycle are both honoured.
- Instruction buffer contents are not reset and persist across runs.

## Timing
- Reset values: cpuIn=0x00, busy=0, done=0, resValid=0, resData=0x00; FIFO emptied, iptr=0, state IDLE. Reset takes effect immediately, including mid-run: the CPU clock drops low asynchronously.
- Start latency: cpuIn[1] rises on the cycle after start is sampled.
- Unstalled run: 2·HALF_PERIOD·(stepCount+1) cycles from the first RSTL cycle to the first FIN cycle.
- Each result enters the FIFO at the end of HIGH. resValid rises the following cycle.
- The instruction is stable for the full CPU clock period around the rising edge. It changes only at SETUP entry.
- stepCount=0: reset pulse only, no results.
- stepCount>DEPTH: instructions wrap to buf[0].

## Configuration
- HIDDEN_CPU_DRIVER_TRACE_EN defined: result FIFO present, with stalling as above.
- Undefined:
  - No FIFO; resValid=0 and resData=0x00 always.
  - SETUP never stalls.
  - resReady is ignored.

## Structure
- Package hidden_cpu_drv_pkg holds:
  - the state enum;
  - cpuIn bit indices (CLK_BIT=0, RST_BIT=1, INSTR_LSB=2);
  - opcode field constants (2-bit opcode, 4-bit address field).
- One sub-module: hidden_cpu_res_fifo, a synchronous FIFO with push, pop, full and empty outputs, parameterised by FIFO_DEPTH. It is instantiated only under the macro.

## Test plan
1. Reset: assert rst=0 mid-idle → cpuIn=0x00, busy=0, resValid=0.
2. Basic run, HALF_PERIOD=2, resReady=1:
   - Stimulus: load buf[0..2]=0x05,0x2A,0x3F; start with stepCount=3.
   - cpuIn[1]=1 for cycles 1–4.
   - cpuIn[7:2] equals 0x05, 0x2A, 0x3F for four cycles each.
   - done pulses on cycle 17.
   - Three results equal to the reference CPU model's r3 (r3 resets to 0x03).
3. Stall, with the macro defined: resReady=0, stepCount=6 → exactly 4 results, then SETUP holds cpuIn[0]=0. Raising resReady drains the FIFO, and the remaining 2 steps complete.
4. Wrap: stepCount=20 → step 17 issues buf[0].
5. Reset mid-HIGH: rst=0 → cpuIn=0x00 and busy=0 without waiting for clk, FIFO empty. A new start then runs normally.
6. stepCount=0 → one reset edge, done on cycle 5, no results. Also, progWe during busy leaves the buffer unchanged.
